// File: rtl/mat_pkg.sv
// Shared types and constants for the matrix loader.
// Optional checksum build: define MATLD_CHECKSUM_EN.
package mat_pkg;

  localparam int MAX_SIZE = 16;
  localparam int SIZE_W   = 5;
  localparam int TOTAL_W  = 10;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    START,
    ERR
  } state_t;

endpackage

// File: rtl/mat_load_ctrl_if.sv
// Element stream handshake between a producer and the loader.
// Producer is master, loader is slave.
interface mat_load_ctrl_if;

  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );

endinterface

// File: rtl/mat_size_check.sv
// Size legality check and element total for one job.
// total = size1*size2 + size2*size3 (fits 10 bits for legal sizes).
module mat_size_check
  import mat_pkg::*;
#(
  parameter int MAX_SIZE = mat_pkg::MAX_SIZE
) (
  input  logic [SIZE_W-1:0]  size1,
  input  logic [SIZE_W-1:0]  size2,
  input  logic [SIZE_W-1:0]  size3,
  output logic               ok,
  output logic [TOTAL_W-1:0] total
);

  function automatic logic legal(input logic [SIZE_W-1:0] s);
    return (s != '0) && (int'(s) <= MAX_SIZE);
  endfunction

  always_comb begin
    ok    = legal(size1) && legal(size2) && legal(size3);
    total = TOTAL_W'(size1) * TOTAL_W'(size2)
          + TOTAL_W'(size2) * TOTAL_W'(size3);
  end

endmodule

// File: rtl/mat_load_ctrl.sv
// Loads mat_A then mat_B into the multiplier input memory.
// Optional checksum output: define MATLD_CHECKSUM_EN.
module mat_load_ctrl
  import mat_pkg::*;
#(
  parameter int BASE_ADDR = 0,
  parameter int MAX_SIZE  = mat_pkg::MAX_SIZE,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  input  logic [SIZE_W-1:0] size1,
  input  logic [SIZE_W-1:0] size2,
  input  logic [SIZE_W-1:0] size3,
  mat_load_ctrl_if.slave    bus,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              mem_wen,
  output logic              start_r,
  input  logic              finish_r,
  output logic              busy,
  output logic              err,
  output logic              load_done
`ifdef MATLD_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  state_t             state;
  state_t             next;
  logic [TOTAL_W-1:0] total;
  logic [TOTAL_W-1:0] count;
  logic               ok;
  logic [TOTAL_W-1:0] new_total;
  logic               hs;
  logic               last_idx;
  logic               cfg_take;

  mat_size_check #(
    .MAX_SIZE (MAX_SIZE)
  ) u_check (
    .size1 (size1),
    .size2 (size2),
    .size3 (size3),
    .ok    (ok),
    .total (new_total)
  );

  assign bus.in_ready = (state == LOAD);
  assign start_r      = (state == START);
  assign busy         = (state != IDLE) && (state != ERR);

  assign hs       = bus.in_valid && bus.in_ready;
  assign last_idx = (count == total - 1'b1);
  assign cfg_take = cfg_valid && ((state == IDLE) || (state == ERR));

  always_comb begin
    next = state;
    unique case (state)
      IDLE, ERR: begin
        if (cfg_valid) next = ok ? LOAD : ERR;
      end
      LOAD: begin
        // Either end-of-count or in_last closes the job.
        if (hs && (last_idx || bus.in_last))
          next = (last_idx && bus.in_last) ? SETTLE : ERR;
      end
      SETTLE: next = START;
      START: begin
        if (finish_r) next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_waddr <= ADDR_W'(BASE_ADDR);
      mem_wdata <= '0;
      mem_wen   <= 1'b0;
      err       <= 1'b0;
      load_done <= 1'b0;
      total     <= '0;
      count     <= '0;
    end else begin
      mem_wen   <= hs;
      load_done <= (state == START) && finish_r;
      if (hs) begin
        mem_waddr <= ADDR_W'(BASE_ADDR) + ADDR_W'(count);
        mem_wdata <= {16'h0000, bus.in_data};
        count     <= count + 1'b1;
      end
      if (cfg_take) begin
        total <= new_total;
        count <= '0;
        err   <= !ok;
      end else if (state == LOAD && next == ERR) begin
        err <= 1'b1;
      end
    end
  end

`ifdef MATLD_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           checksum <= '0;
    else if (cfg_take) checksum <= '0;
    else if (hs)       checksum <= checksum + {16'h0000, bus.in_data};
  end
`endif

endmodule

// File: tb/tb_mat_load_ctrl.sv
// Directed bench for mat_load_ctrl.
// Define MATLD_CHECKSUM_EN to also cover the checksum output.
module tb_mat_load_ctrl;
  import mat_pkg::*;

  logic        clk;
  logic        rst;
  logic        cfg_valid;
  logic [4:0]  size1, size2, size3;
  logic [15:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic        mem_wen, start_r, finish_r, busy, err, load_done;
`ifdef MATLD_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int total;
  int bad;

  mat_load_ctrl_if bus ();

  mat_load_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .size1     (size1),
    .size2     (size2),
    .size3     (size3),
    .bus       (bus),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_wen   (mem_wen),
    .start_r   (start_r),
    .finish_r  (finish_r),
    .busy      (busy),
    .err       (err),
    .load_done (load_done)
`ifdef MATLD_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input int s1, input int s2, input int s3);
    cfg_valid = 1'b1;
    size1 = 5'(s1);
    size2 = 5'(s2);
    size3 = 5'(s3);
    step;
    cfg_valid = 1'b0;
  endtask

  // Full job: cfg, stream every element, start_r timing, finish handoff.
  task automatic load_job(input int s1, input int s2, input int s3,
                          input bit all_ff);
    int n;
    logic [15:0] d;
    logic [31:0] sum;
    n = s1 * s2 + s2 * s3;
    sum = 0;
    do_cfg(s1, s2, s3);
    total++;
    if ({bus.in_ready, busy, err} !== 3'b110) begin
      $display("FAIL job_cfg: got rdy/busy/err=%b want 110",
               {bus.in_ready, busy, err});
      bad++;
    end
    for (int i = 0; i < n; i++) begin
      d = all_ff ? 16'hFFFF : 16'(i + 1);
      sum = sum + {16'h0, d};
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = (i == n - 1);
      step;
      total++;
      if (mem_wen !== 1'b1 || mem_waddr !== 16'(i)
          || mem_wdata !== {16'h0, d}) begin
        $display("FAIL job_write%0d: got wen=%b a=%h d=%h want 1 %h %h",
                 i, mem_wen, mem_waddr, mem_wdata, 16'(i), {16'h0, d});
        bad++;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    total++;
    if ({start_r, bus.in_ready} !== 2'b00) begin
      $display("FAIL job_settle: got start/rdy=%b want 00",
               {start_r, bus.in_ready});
      bad++;
    end
    step;
    total++;
    if ({start_r, mem_wen, busy} !== 3'b101) begin
      $display("FAIL job_start: got start/wen/busy=%b want 101",
               {start_r, mem_wen, busy});
      bad++;
    end
    step;
    step;
    total++;
    if (start_r !== 1'b1) begin
      $display("FAIL job_hold: got start_r=%b want 1", start_r);
      bad++;
    end
    finish_r = 1'b1;
    step;
    finish_r = 1'b0;
    total++;
    if ({start_r, load_done, busy, err} !== 4'b0100) begin
      $display("FAIL job_done: got start/done/busy/err=%b want 0100",
               {start_r, load_done, busy, err});
      bad++;
    end
`ifdef MATLD_CHECKSUM_EN
    total++;
    if (checksum !== sum) begin
      $display("FAIL job_checksum: got %h want %h", checksum, sum);
      bad++;
    end
`endif
    step;
    total++;
    if (load_done !== 1'b0) begin
      $display("FAIL job_pulse: got load_done=%b want 0", load_done);
      bad++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    total++;
    if ({bus.in_ready, mem_wen, start_r, busy, err, load_done} !== 6'b0
        || mem_waddr !== 16'h0 || mem_wdata !== 32'h0) begin
      $display("FAIL reset: got flags=%b a=%h d=%h want 0",
               {bus.in_ready, mem_wen, start_r, busy, err, load_done},
               mem_waddr, mem_wdata);
      bad++;
    end
    #20 rst = 1'b0;
    step;
    // finish_r outside START must be ignored
    finish_r = 1'b1;
    step;
    finish_r = 1'b0;
    step;
    total++;
    if ({load_done, busy, start_r} !== 3'b000) begin
      $display("FAIL idle_finish: got done/busy/start=%b want 000",
               {load_done, busy, start_r});
      bad++;
    end
  endtask

  task automatic test_basic;
    load_job(2, 2, 2, 1'b0);
  endtask

  task automatic test_stall;
    int n;
    n = 0;
    do_cfg(3, 2, 4);
    for (int k = 0; k < 40 && n < 14; k++) begin
      bus.in_valid = (k % 2 == 0);
      bus.in_data  = 16'(n + 1);
      bus.in_last  = (n == 13);
      step;
      total++;
      if (k % 2 == 0) begin
        if (mem_wen !== 1'b1 || mem_waddr !== 16'(n)
            || mem_wdata !== 32'(n + 1)) begin
          $display("FAIL stall_write%0d: got wen=%b a=%h d=%h want 1 %h %h",
                   n, mem_wen, mem_waddr, mem_wdata, 16'(n), 32'(n + 1));
          bad++;
        end
        n++;
      end else if (mem_wen !== 1'b0) begin
        $display("FAIL stall_gap%0d: got wen=%b want 0", k, mem_wen);
        bad++;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    total++;
    if (n != 14) begin
      $display("FAIL stall_count: got %0d want 14", n);
      bad++;
    end
    step;
    total++;
    if (start_r !== 1'b1) begin
      $display("FAIL stall_start: got start_r=%b want 1", start_r);
      bad++;
    end
    finish_r = 1'b1;
    step;
    finish_r = 1'b0;
    total++;
    if ({load_done, busy} !== 2'b10) begin
      $display("FAIL stall_done: got done/busy=%b want 10",
               {load_done, busy});
      bad++;
    end
    step;
  endtask

  task automatic test_bad_size;
    do_cfg(2, 17, 2);
    total++;
    if ({err, bus.in_ready, busy} !== 3'b100) begin
      $display("FAIL badsize: got err/rdy/busy=%b want 100",
               {err, bus.in_ready, busy});
      bad++;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h55;
    step;
    step;
    total++;
    if ({mem_wen, bus.in_ready, err} !== 3'b001) begin
      $display("FAIL badsize_hold: got wen/rdy/err=%b want 001",
               {mem_wen, bus.in_ready, err});
      bad++;
    end
    bus.in_valid = 1'b0;
    load_job(1, 1, 1, 1'b0);
  endtask

  task automatic test_early_last;
    do_cfg(2, 2, 2);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'(i + 1);
      bus.in_last  = (i == 4);
      step;
      total++;
      if (mem_wen !== 1'b1 || mem_waddr !== 16'(i)) begin
        $display("FAIL early_write%0d: got wen=%b a=%h want 1 %h",
                 i, mem_wen, mem_waddr, 16'(i));
        bad++;
      end
    end
    total++;
    if ({err, bus.in_ready} !== 2'b10) begin
      $display("FAIL early_err: got err/rdy=%b want 10",
               {err, bus.in_ready});
      bad++;
    end
    bus.in_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step;
      total++;
      if ({mem_wen, start_r, bus.in_ready, err} !== 4'b0001) begin
        $display("FAIL early_hold%0d: got wen/start/rdy/err=%b want 0001",
                 i, {mem_wen, start_r, bus.in_ready, err});
        bad++;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_async_reset;
    do_cfg(2, 2, 2);
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'(i + 1);
      bus.in_last  = 1'b0;
      step;
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({bus.in_ready, mem_wen, start_r, busy, err, load_done} !== 6'b0
        || mem_waddr !== 16'h0 || mem_wdata !== 32'h0) begin
      $display("FAIL async_reset: got flags=%b a=%h d=%h want 0",
               {bus.in_ready, mem_wen, start_r, busy, err, load_done},
               mem_waddr, mem_wdata);
      bad++;
    end
    bus.in_valid = 1'b0;
    step;
    rst = 1'b0;
    step;
    load_job(2, 2, 2, 1'b0);
  endtask

  task automatic test_checksum;
`ifdef MATLD_CHECKSUM_EN
    load_job(16, 16, 16, 1'b1);
    total++;
    if (checksum !== 32'h01FF_FE00) begin
      $display("FAIL checksum_full: got %h want 01fffe00", checksum);
      bad++;
    end
`endif
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cfg_valid = 1'b0;
    size1 = '0;
    size2 = '0;
    size3 = '0;
    finish_r = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    test_reset;
    test_basic;
    test_stall;
    test_bad_size;
    test_early_last;
    test_async_reset;
    test_checksum;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mat_load_ctrl.md
Name: mat_load_ctrl

Overview:
- Upstream loader for the 16-bit matrix multiplier.
- Accepts a configuration (size1, size2, size3) and a valid/ready stream of 16-bit elements: all of mat_A row-major, then all of mat_B row-major.
- Writes the elements linearly into the shared input memory, which the multiplier later reads through raddr/rdata.
- Asserts start_r to launch the multiplier's read phase, then waits for its finish_r before accepting the next job.

Parameters:
BASE_ADDR, 0, first input-memory word address written for element 0
MAX_SIZE, 16, largest legal matrix dimension
ADDR_W, 16, memory address width

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-high
cfg_valid  input  1  sample size1/size2/size3 (honoured only in IDLE or ERR)
size1  input  5  mat_A rows
size2  input  5  mat_A columns = mat_B rows
size3  input  5  mat_B columns
in_valid  input  1  element stream valid
in_ready  output  1  element stream ready
in_data  input  16  element value (unsigned)
in_last  input  1  marks the final element of the job
mem_waddr  output  ADDR_W  input-memory write address
mem_wdata  output  32  input-memory write data
mem_wen  output  1  input-memory write enable
start_r  output  1  multiplier read start, level
finish_r  input  1  multiplier read-phase complete
busy  output  1  high in any state other than IDLE/ERR
err  output  1  configuration or framing error, sticky until next cfg_valid
load_done  output  1  one-cycle pulse when the job is handed off

Behaviour:
- Reset values: in_ready=0, mem_waddr=BASE_ADDR, mem_wdata=0, mem_wen=0, start_r=0, busy=0, err=0, load_done=0; state=IDLE; element count=0.
- Reset is asynchronous and may arrive mid-load. It returns the block to the reset values within the same cycle. Words already written stay in memory.
- State machine: IDLE, LOAD, SETTLE, START, ERR.
- IDLE, on cfg_valid:
  - Register the three sizes.
  - Compute total = size1*size2 + size2*size3 as a 10-bit value (max 512).
  - If any size is 0 or greater than MAX_SIZE, go to ERR and set err=1.
  - Otherwise clear err and count, and go to LOAD.
- LOAD:
  - in_ready=1 (combinational from state).
  - On each handshake (in_valid && in_ready), the next cycle drives mem_wen=1, mem_waddr=BASE_ADDR+count, mem_wdata={16'h0000, in_data}. count then increments.
  - Write latency is exactly 1 cycle after the handshake. mem_wen=0 in every cycle that follows a cycle with no handshake.
  - Handshake with count==total-1: in_last must be 1. The element is written, and the next state is SETTLE.
  - Handshake with count==total-1 and in_last=0: the element is still written, and the next state is ERR.
  - Handshake with count<total-1 and in_last=1: the element is written, the next state is ERR, and the remaining stream is not accepted.
- SETTLE:
  - One cycle, in_ready=0. The final registered write completes here.
  - Next state is START.
- START:
  - start_r=1, held as a level.
  - When finish_r=1 is sampled, drop start_r, pulse load_done for one cycle, and return to IDLE.
  - finish_r arriving while not in START is ignored.
- ERR:
  - in_ready=0, err=1, start_r=0.
  - cfg_valid re-runs the IDLE size check in the same way.
- cfg_valid is ignored in LOAD, SETTLE and START.
- Timing: start_r rises exactly 2 cycles after the final handshake.
- Address arithmetic: BASE_ADDR+count is truncated to ADDR_W bits and wraps silently.

Optional Feature:
- MATLD_CHECKSUM_EN defined:
  - Adds output port checksum (32 bits): the sum of zero-extended in_data over all accepted elements, mod 2^32.
  - checksum is cleared on an accepted cfg_valid.
  - It is stable and valid while load_done=1 and until the next accepted cfg_valid.
  - On ERR it holds the partial sum.
- MATLD_CHECKSUM_EN undefined: the port and the accumulator are absent. All other behaviour is identical.

Decomposition:
- Shared package mat_pkg holds:
  - MAX_SIZE=16 and the SIZE_W=5 constant.
  - The state enum type (IDLE, LOAD, SETTLE, START, ERR).
  - The TOTAL_W=10 constant used for element counts.
- One sub-module, mat_size_check: combinational legality check, plus the total computation from size1/2/3 (valid flag and 10-bit total).

Test Plan:
- 2x2 x 2x2, elements 1..8, in_valid held high:
  - mem_wen high for 8 consecutive cycles, waddr 0..7, wdata 0x00000001..0x00000008.
  - start_r high 2 cycles after the 8th handshake.
  - finish_r pulse -> load_done for 1 cycle, busy=0.
- 3x2 x 2x4 (total 14) with in_valid toggled every other cycle: 14 writes at addresses 0..13 with gaps matching the stall pattern; no write in a stall cycle.
- size2=17 on cfg_valid: err=1, state ERR, in_ready stays 0. A second cfg_valid with 1,1,1 clears err and accepts 2 elements.
- 2x2 x 2x2 with in_last on element 5: 5 writes occur, then err=1, in_ready=0, start_r never asserts.
- rst asserted asynchronously after 3 of 8 elements: all outputs return to reset values immediately; a following full job loads from address 0 correctly.
- With MATLD_CHECKSUM_EN, 16x16 x 16x16, all elements 0xFFFF: checksum = 512*65535 = 0x01FFFE00 at load_done.
